// File: rtl/dezigzag_dequant.sv
// Dequantises a 64-coefficient zigzag block with a loadable quant table and reorders it to raster order.
// Optional feature macro: DEQ_SATURATE_EN (clamp products to OUT_W range instead of two's-complement wrap).
module dezigzag_dequant #(
  parameter int LANES = 4,
  parameter int QT_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [63:0][11:0]        in_data_i,
  input  logic                     in_valid_i,
  input  logic                     qt_wr_en_i,
  input  logic [5:0]               qt_addr_i,
  input  logic [QT_W-1:0]          qt_data_i,
  output logic [63:0][OUT_W-1:0]   out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     overflow_o,
  output logic                     busy_o
);

  localparam int NCYC = 64 / LANES;
  localparam int CW   = $clog2(NCYC);
  localparam int PW   = 12 + QT_W + 1;

  // Zigzag position -> natural raster index.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

`ifdef DEQ_SATURATE_EN
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2**(OUT_W-1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic [1:0] {IDLE, PROC, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     pending_q, pending_d;
  logic [63:0][11:0]        in_reg_q, in_reg_d;
  logic [63:0][OUT_W-1:0]   out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overflow_q, overflow_d;
  logic [QT_W-1:0]          qt_q [64];
  logic                     last_proc, reg_free;
  logic [5:0]               zz_pos, nat_idx;

  function automatic logic signed [PW-1:0] dequant(input logic [11:0] c, input logic [QT_W-1:0] q);
    return $signed(c) * $signed({1'b0, q});
  endfunction

  function automatic logic [OUT_W-1:0] narrow(input logic signed [PW-1:0] p);
`ifdef DEQ_SATURATE_EN
    if (p > SAT_MAX) return {1'b0, {(OUT_W-1){1'b1}}};
    else if (p < SAT_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
    else return OUT_W'(p);
`else
    return OUT_W'(p);
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    in_reg_d    = in_reg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    zz_pos      = '0;
    nat_idx     = '0;
    last_proc   = (state_q == PROC) && (cnt_q == CW'(NCYC - 1));
    // The input register frees on the edge that finishes the last lane group.
    reg_free    = !pending_q || last_proc;

    if (in_valid_i && reg_free) begin
      in_reg_d  = in_data_i;
      pending_d = 1'b1;
    end else begin
      if (in_valid_i) overflow_d = 1'b1;
      if (last_proc) pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = PROC;
          cnt_d   = '0;
        end
      end
      PROC: begin
        for (int j = 0; j < LANES; j++) begin
          zz_pos  = 6'(int'(cnt_q) * LANES + j);
          nat_idx = ZZ[zz_pos];
          out_data_d[nat_idx] = narrow(dequant(in_reg_q[zz_pos], qt_q[nat_idx]));
        end
        cnt_d = cnt_q + CW'(1);
        if (last_proc) begin
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = pending_q ? PROC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      in_reg_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      in_reg_q    <= in_reg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Table writes land at the edge, so a same-cycle PROC read sees the old entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 64; i++) qt_q[i] <= QT_W'(1);
    end else if (qt_wr_en_i) begin
      qt_q[qt_addr_i] <= qt_data_i;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q != IDLE) || pending_q;

endmodule

// File: tb/tb_dezigzag_dequant.sv
// Scoreboard bench for dezigzag_dequant: expected blocks are queued at send time and compared on out_valid.
module tb_dezigzag_dequant;

  typedef logic [63:0][11:0] iblk_t;
  typedef logic [63:0][15:0] oblk_t;

  logic        clk;
  logic        rst;
  iblk_t       in_data;
  logic        in_valid;
  logic        qt_wr_en;
  logic [5:0]  qt_addr;
  logic [7:0]  qt_data;
  oblk_t       out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  oblk_t       exp_q[$];
  logic [7:0]  qt_m [64];
  int          zz_nat [64];

  dezigzag_dequant dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .qt_wr_en_i  (qt_wr_en),
    .qt_addr_i   (qt_addr),
    .qt_data_i   (qt_data),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .overflow_o  (overflow),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zigzag traversal built by walking anti-diagonals.
  function automatic void build_zz();
    int idx = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz_nat[idx] = r * 8 + (s - r);
          idx++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz_nat[idx] = r * 8 + (s - r);
          idx++;
        end
      end
    end
  endfunction

  function automatic oblk_t model(input iblk_t d);
    oblk_t  r;
    longint p;
    int     n;
    r = '0;
    for (int k = 0; k < 64; k++) begin
      n = zz_nat[k];
      p = longint'($signed(d[k])) * longint'(qt_m[n]);
`ifdef DEQ_SATURATE_EN
      if (p > 32767) r[n] = 16'h7FFF;
      else if (p < -32768) r[n] = 16'h8000;
      else r[n] = p[15:0];
`else
      r[n] = p[15:0];
`endif
    end
    return r;
  endfunction

  function automatic int first_diff(input oblk_t a, input oblk_t b);
    for (int i = 0; i < 64; i++) if (a[i] !== b[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_qt(input logic [5:0] a, input logic [7:0] d);
    qt_wr_en = 1'b1;
    qt_addr  = a;
    qt_data  = d;
    tick();
    qt_wr_en = 1'b0;
    qt_m[a]  = d;
  endtask

  task automatic send_block(input iblk_t d, input bit expect_capture);
    in_data  = d;
    in_valid = 1'b1;
    if (expect_capture) exp_q.push_back(model(d));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (out_valid !== 1'b1 && cycles < 40);
    if (out_valid !== 1'b1) cycles = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; qt_wr_en = 1'b0; qt_addr = '0; qt_data = '0;
    in_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 64; i++) qt_m[i] = 8'd1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data[first_diff(out_data, '0)]); end
  endtask

  task automatic test_identity();
    iblk_t d;
    oblk_t e;
    int    cyc;
    for (int k = 0; k < 64; k++) d[k] = 12'(k);
    send_block(d, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL identity_busy: got %b expected 1", busy); end
    wait_out_valid(cyc);
    checks++; if (cyc != 17) begin errors++; $display("[TB] FAIL identity_latency: got %0d expected 17", cyc); end
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) begin
      errors++;
      $display("[TB] FAIL identity_block: out_data[%0d]=%h expected %h", first_diff(out_data, e), out_data[first_diff(out_data, e)], e[first_diff(out_data, e)]);
    end
    checks++; if (out_data[63] !== 16'd63 || out_data[8] !== 16'd2) begin errors++; $display("[TB] FAIL identity_zz: out_data[63]=%h out_data[8]=%h expected 003f 0002", out_data[63], out_data[8]); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL identity_accept: valid=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  task automatic test_dequant();
    iblk_t d;
    oblk_t e;
    int    cyc;
    write_qt(6'd8, 8'd10);
    d = '0;
    d[2] = 12'hFF9;
    send_block(d, 1'b1);
    wait_out_valid(cyc);
    checks++; if (cyc != 17) begin errors++; $display("[TB] FAIL dequant_latency: got %0d expected 17", cyc); end
    e = exp_q.pop_front();
    checks++; if (out_data[8] !== 16'hFFBA) begin errors++; $display("[TB] FAIL dequant_value: got %h expected ffba", out_data[8]); end
    checks++;
    if (out_data !== e) begin
      errors++;
      $display("[TB] FAIL dequant_block: out_data[%0d]=%h expected %h", first_diff(out_data, e), out_data[first_diff(out_data, e)], e[first_diff(out_data, e)]);
    end
    tick();
  endtask

  task automatic test_saturation();
    iblk_t d;
    oblk_t e;
    int    cyc;
    logic [15:0] exp_pos, exp_neg;
`ifdef DEQ_SATURATE_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
    exp_pos = 16'hF701; exp_neg = 16'h0800;
`endif
    write_qt(6'd0, 8'd255);
    write_qt(6'd1, 8'd255);
    d = '0;
    d[0] = 12'h7FF;
    d[1] = 12'h800;
    send_block(d, 1'b1);
    wait_out_valid(cyc);
    e = exp_q.pop_front();
    checks++; if (out_data[0] !== exp_pos) begin errors++; $display("[TB] FAIL sat_pos: got %h expected %h", out_data[0], exp_pos); end
    checks++; if (out_data[1] !== exp_neg) begin errors++; $display("[TB] FAIL sat_neg: got %h expected %h", out_data[1], exp_neg); end
    checks++;
    if (out_data !== e) begin
      errors++;
      $display("[TB] FAIL sat_block: out_data[%0d]=%h expected %h", first_diff(out_data, e), out_data[first_diff(out_data, e)], e[first_diff(out_data, e)]);
    end
    tick();
  endtask

  task automatic test_overflow();
    iblk_t a, b, c;
    oblk_t e;
    int    cyc;
    int    seen;
    for (int k = 0; k < 64; k++) begin
      a[k] = 12'(k * 3 - 50);
      b[k] = 12'(100 - k);
      c[k] = 12'(7);
    end
    out_ready = 1'b0;
    send_block(a, 1'b1);
    wait_out_valid(cyc);
    checks++; if (cyc != 17) begin errors++; $display("[TB] FAIL ovf_a_latency: got %0d expected 17", cyc); end
    send_block(b, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_b_captured: overflow=%b expected 0", overflow); end
    send_block(c, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_c_dropped: overflow=%b expected 1", overflow); end
    repeat (3) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_hold_valid: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) begin
      errors++;
      $display("[TB] FAIL ovf_block_a: out_data[%0d]=%h expected %h", first_diff(out_data, e), out_data[first_diff(out_data, e)], e[first_diff(out_data, e)]);
    end
    wait_out_valid(cyc);
    checks++; if (cyc != 17) begin errors++; $display("[TB] FAIL ovf_b_latency: got %0d expected 17", cyc); end
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) begin
      errors++;
      $display("[TB] FAIL ovf_block_b: out_data[%0d]=%h expected %h", first_diff(out_data, e), out_data[first_diff(out_data, e)], e[first_diff(out_data, e)]);
    end
    tick();
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_c_lost: valid cycles=%0d busy=%b expected 0 0", seen, busy); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_mid();
    iblk_t d;
    oblk_t e;
    int    cyc;
    out_ready = 1'b1;
    write_qt(6'd8, 8'd10);
    d = '0;
    d[2] = 12'hFF9;
    send_block(d, 1'b0);
    repeat (6) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) qt_m[i] = 8'd1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_flags: valid=%b busy=%b ovf=%b expected 0 0 0", out_valid, busy, overflow); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL rstmid_data: out_data[%0d]=%h expected 0", first_diff(out_data, '0), out_data[first_diff(out_data, '0)]); end
    send_block(d, 1'b1);
    wait_out_valid(cyc);
    checks++; if (cyc != 17) begin errors++; $display("[TB] FAIL rstmid_latency: got %0d expected 17", cyc); end
    e = exp_q.pop_front();
    checks++; if (out_data[8] !== 16'hFFF9) begin errors++; $display("[TB] FAIL rstmid_qt_reset: got %h expected fff9", out_data[8]); end
    checks++;
    if (out_data !== e) begin
      errors++;
      $display("[TB] FAIL rstmid_block: out_data[%0d]=%h expected %h", first_diff(out_data, e), out_data[first_diff(out_data, e)], e[first_diff(out_data, e)]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    iblk_t a, b;
    oblk_t e;
    int    cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) write_qt(6'($urandom_range(0, 63)), 8'($urandom));
    for (int k = 0; k < 64; k++) begin
      a[k] = 12'($urandom);
      b[k] = 12'($urandom);
    end
    send_block(a, 1'b1);
    repeat (16) tick();
    send_block(b, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_a_valid: got %b expected 1", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_drop: overflow=%b expected 0", overflow); end
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) begin
      errors++;
      $display("[TB] FAIL b2b_block_a: out_data[%0d]=%h expected %h", first_diff(out_data, e), out_data[first_diff(out_data, e)], e[first_diff(out_data, e)]);
    end
    wait_out_valid(cyc);
    checks++; if (cyc != 17) begin errors++; $display("[TB] FAIL b2b_b_latency: got %0d expected 17", cyc); end
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) begin
      errors++;
      $display("[TB] FAIL b2b_block_b: out_data[%0d]=%h expected %h", first_diff(out_data, e), out_data[first_diff(out_data, e)], e[first_diff(out_data, e)]);
    end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: valid=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  initial begin
    build_zz();
    test_reset();
    test_identity();
    test_dequant();
    test_saturation();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
